// File: rtl/rpn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rpn_pkg : opcodes, error codes and FSM encoding for rpn_sequencer    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package rpn_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POPB = 3'd1,
    S_GETB = 3'd2,
    S_GETA = 3'd3,
    S_PUSH = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rpn_alu : combinational A op B, modulo 2^DATA_WIDTH                  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rpn_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rpn_sequencer : RPN token sequencer driving an external stack        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  err,
  output logic [1:0]            err_code
);

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [2:0]              r_op;
  logic [DATA_WIDTH-1:0]   w_alu_y;
  logic                    w_latch_op;
  logic                    w_latch_a;
  logic                    w_latch_b;
  logic                    w_push_result;
  logic                    w_set_err;
  logic [1:0]              w_err_code;

  rpn_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .y  (w_alu_y)
  );

  always_comb begin
    w_state_nx    = r_state;
    tok_ready     = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_wdata     = '0;
    w_latch_op    = 1'b0;
    w_latch_a     = 1'b0;
    w_latch_b     = 1'b0;
    w_push_result = 1'b0;
    w_set_err     = 1'b0;
    w_err_code    = ERR_NONE;
    case (r_state)
      S_IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (!stk_full) begin
              stk_push  = 1'b1;
              stk_wdata = tok_data;
            end else begin
              w_set_err  = 1'b1;
              w_err_code = ERR_OVERFLOW;
              w_state_nx = S_ERR;
            end
          end else if (is_legal_op(tok_data[2:0])) begin
            w_latch_op = 1'b1;
            w_state_nx = S_POPB;
          end else begin
            w_set_err  = 1'b1;
            w_err_code = ERR_ILLEGAL;
            w_state_nx = S_ERR;
          end
        end
      end
      S_POPB: begin
        if (!stk_empty) begin
          stk_pop    = 1'b1;
          w_state_nx = S_GETB;
        end else begin
          w_set_err  = 1'b1;
          w_err_code = ERR_UNDERFLOW;
          w_state_nx = S_ERR;
        end
      end
      // B is only kept when the second pop can proceed; on underflow it is dropped.
      S_GETB: begin
        if (!stk_empty) begin
          w_latch_b  = 1'b1;
          stk_pop    = 1'b1;
          w_state_nx = S_GETA;
        end else begin
          w_set_err  = 1'b1;
          w_err_code = ERR_UNDERFLOW;
          w_state_nx = S_ERR;
        end
      end
      S_GETA: begin
        w_latch_a  = 1'b1;
        w_state_nx = S_PUSH;
      end
      S_PUSH: begin
        stk_push      = 1'b1;
        stk_wdata     = w_alu_y;
        w_push_result = 1'b1;
        w_state_nx    = S_IDLE;
      end
      S_ERR: begin
        if (clr) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      r_state      <= w_state_nx;
      result_valid <= w_push_result;
      if (w_latch_op)    r_op   <= tok_data[2:0];
      if (w_latch_b)     r_b    <= stk_rdata;
      if (w_latch_a)     r_a    <= stk_rdata;
      if (w_push_result) result <= w_alu_y;
      if (w_set_err) begin
        err      <= 1'b1;
        err_code <= w_err_code;
      end else if (r_state == S_ERR && clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rpn_sequencer : directed + randomized bench with a stack model    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rpn_sequencer;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  tok_valid = 1'b0;
  logic                  tok_ready;
  logic                  tok_is_op = 1'b0;
  logic [DATA_WIDTH-1:0] tok_data = '0;
  logic                  stk_push;
  logic                  stk_pop;
  logic [DATA_WIDTH-1:0] stk_wdata;
  logic [DATA_WIDTH-1:0] stk_rdata = '0;
  logic                  stk_full;
  logic                  stk_empty;
  logic                  clr = 1'b0;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic                  err;
  logic [1:0]            err_code;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  int                    cnt = 0;
  int                    push_cnt = 0;
  int                    pop_cnt = 0;
  logic                  overlap = 1'b0;
  logic                  flush = 1'b0;
  logic                  force_full = 1'b0;

  int tests = 0;
  int fails = 0;

  rpn_sequencer #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_op    (tok_is_op),
    .tok_data     (tok_data),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_wdata    (stk_wdata),
    .stk_rdata    (stk_rdata),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .clr          (clr),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Downstream stack: read data appears the cycle after a pop.
  assign stk_full  = force_full || (cnt == DEPTH);
  assign stk_empty = (cnt == 0);

  always @(posedge clk) begin
    if (flush) begin
      cnt <= 0;
    end else begin
      if (stk_push && stk_pop) overlap <= 1'b1;
      if (stk_push) begin
        push_cnt <= push_cnt + 1;
        if (cnt < DEPTH) begin
          mem[cnt] <= stk_wdata;
          cnt      <= cnt + 1;
        end
      end else if (stk_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (cnt > 0) begin
          stk_rdata <= mem[cnt-1];
          cnt       <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_stack();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic push_operand(input logic [DATA_WIDTH-1:0] v);
    tok_valid = 1'b1;
    tok_is_op = 1'b0;
    tok_data  = v;
    #1;
    check("operand_push", {31'd0, stk_push}, 32'd1);
    check("operand_wdata", {24'd0, stk_wdata}, {24'd0, v});
    step();
    tok_valid = 1'b0;
  endtask

  // Operator presented in cycle 0; push happens in cycle 4; result_valid seen in cycle 5.
  task automatic apply_op(input logic [2:0] op, input logic [DATA_WIDTH-1:0] exp, input string tag);
    tok_valid = 1'b1;
    tok_is_op = 1'b1;
    tok_data  = {5'd0, op};
    step();
    tok_valid = 1'b0;
    repeat (3) step();
    check({tag, "_push_cycle"}, {31'd0, stk_push}, 32'd1);
    check({tag, "_push_data"}, {24'd0, stk_wdata}, {24'd0, exp});
    check({tag, "_rv_early"}, {31'd0, result_valid}, 32'd0);
    step();
    check({tag, "_rv"}, {31'd0, result_valid}, 32'd1);
    check({tag, "_result"}, {24'd0, result}, {24'd0, exp});
  endtask

  task automatic clear_err();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_code", {30'd0, err_code}, 32'd0);
    check("clr_ready", {31'd0, tok_ready}, 32'd1);
  endtask

  function automatic logic [DATA_WIDTH-1:0] ref_calc(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      3:       r = a | b;
      default: r = a ^ b;
    endcase
    return r[DATA_WIDTH-1:0];
  endfunction

  initial begin
    logic [DATA_WIDTH-1:0] model [$];
    logic [DATA_WIDTH-1:0] va, vb, ve;
    int snap_push, snap_pop, op;

    #3;
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    check("rst_push", {31'd0, stk_push}, 32'd0);
    check("rst_pop", {31'd0, stk_pop}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("first_ready", {31'd0, tok_ready}, 32'd1);
    step();

    push_operand(8'd5);
    push_operand(8'd3);
    apply_op(3'b000, 8'd8, "add_5_3");
    check("add_depth", cnt, 1);
    check("add_word", {24'd0, mem[0]}, 32'd8);

    push_operand(8'd2);
    push_operand(8'd7);
    apply_op(3'b001, 8'hFB, "sub_wrap");

    // Operator on an empty stack.
    flush_stack();
    snap_pop = pop_cnt;
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd0;
    step();
    tok_valid = 1'b0;
    check("empty_nopop_popb", {31'd0, stk_pop}, 32'd0);
    step();
    check("empty_err", {31'd0, err}, 32'd1);
    check("empty_code", {30'd0, err_code}, 32'd2);
    check("empty_ready", {31'd0, tok_ready}, 32'd0);
    check("empty_popcnt", pop_cnt, snap_pop);
    clear_err();

    // Underflow on the second pop; stack left empty.
    push_operand(8'd9);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd2;
    step();
    tok_valid = 1'b0;
    repeat (2) step();
    check("getb_uf_code", {30'd0, err_code}, 32'd2);
    check("getb_uf_depth", cnt, 0);
    clear_err();

    // Operand push against a full stack.
    force_full = 1'b1;
    snap_push = push_cnt;
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'h44;
    #1;
    check("full_nopush", {31'd0, stk_push}, 32'd0);
    step();
    tok_valid = 1'b0;
    force_full = 1'b0;
    check("full_err", {31'd0, err}, 32'd1);
    check("full_code", {30'd0, err_code}, 32'd1);
    check("full_pushcnt", push_cnt, snap_push);
    clear_err();

    // Illegal opcode; err_code must hold while clr is absent.
    snap_push = push_cnt;
    snap_pop  = pop_cnt;
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd7;
    step();
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'd1;
    #1;
    check("ill_ready", {31'd0, tok_ready}, 32'd0);
    check("ill_code", {30'd0, err_code}, 32'd3);
    repeat (2) step();
    tok_valid = 1'b0;
    check("ill_code_hold", {30'd0, err_code}, 32'd3);
    check("ill_pushcnt", push_cnt, snap_push);
    check("ill_popcnt", pop_cnt, snap_pop);
    clear_err();

    // Reset asserted while in GETB.
    push_operand(8'd4);
    push_operand(8'd9);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd0;
    step();
    tok_valid = 1'b0;
    step();
    check("getb_pop", {31'd0, stk_pop}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_pop", {31'd0, stk_pop}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    snap_push = push_cnt;
    snap_pop  = pop_cnt;
    repeat (2) step();
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, tok_ready}, 32'd1);
    repeat (4) step();
    check("midrst_pushcnt", push_cnt, snap_push);
    check("midrst_popcnt", pop_cnt, snap_pop);

    // Randomized token stream against a queue model of the stack.
    flush_stack();
    for (int i = 0; i < 30; i++) begin
      if (model.size() < 2 || (model.size() < DEPTH && $urandom_range(0, 1) == 0)) begin
        va = DATA_WIDTH'($urandom_range(0, 255));
        push_operand(va);
        model.push_back(va);
      end else begin
        op = int'($urandom_range(0, 4));
        vb = model.pop_back();
        va = model.pop_back();
        ve = ref_calc(int'(va), int'(vb), op);
        apply_op(3'(op), ve, "rand_op");
        model.push_back(ve);
      end
    end
    check("rand_depth", cnt, model.size());
    for (int k = 0; k < model.size(); k++)
      check("rand_word", {24'd0, mem[k]}, {24'd0, model[k]});

    check("no_push_pop_overlap", {31'd0, overlap}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the operand, result and stack word width.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port tok_valid, input, 1: a token is presented this cycle.
REQ-005 Port tok_ready, output, 1: the sequencer accepts a token this cycle; a transfer occurs when tok_valid and tok_ready are both high at the edge.
REQ-006 Port tok_is_op, input, 1: 1 means an operator token, 0 means an operand token.
REQ-007 Port tok_data, input, DATA_WIDTH: the operand value, or the opcode in bits [2:0].
REQ-008 Port stk_push, output, 1: push request to the downstream stack.
REQ-009 Port stk_pop, output, 1: pop request to the downstream stack.
REQ-010 Port stk_wdata, output, DATA_WIDTH: the push data.
REQ-011 Port stk_rdata, input, DATA_WIDTH: the stack read data, valid in the cycle after a pop.
REQ-012 Port stk_full, input, 1 and port stk_empty, input, 1: the stack occupancy levels.
REQ-013 Port clr, input, 1: synchronous error clear.
REQ-014 Port result, output, DATA_WIDTH: the last computed value, registered.
REQ-015 Port result_valid, output, 1: a one-cycle pulse when result is pushed.
REQ-016 Port err, output, 1 and port err_code, output, 2: the sticky error flag and its cause (01 overflow, 10 underflow, 11 illegal opcode).

Function
REQ-017 The FSM SHALL have the states IDLE, POPB, GETB, GETA, PUSH and ERR.
REQ-018 tok_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, an operand transfer SHALL drive stk_push=1 and stk_wdata=tok_data in the same cycle when stk_full=0; when stk_full=1 it SHALL drive no push, set err_code=01 and go to ERR.
REQ-020 In IDLE, an operator transfer SHALL latch the opcode and go to POPB, or SHALL go to ERR with err_code=11 when the opcode is greater than 100.
REQ-021 POPB SHALL assert stk_pop and go to GETB when stk_empty=0, else go to ERR with err_code=10.
REQ-022 GETB SHALL latch B=stk_rdata, then assert stk_pop and go to GETA when stk_empty=0, else go to ERR with err_code=10.
REQ-023 GETA SHALL latch A=stk_rdata and go to PUSH.
REQ-024 PUSH SHALL drive stk_push=1 with stk_wdata=A op B (no stk_full check), register result, pulse result_valid, and return to IDLE.
REQ-025 The opcodes SHALL be 000 A+B, 001 A-B, 010 A&B, 011 A|B and 100 A^B; arithmetic SHALL be modulo 2^DATA_WIDTH with carry and borrow discarded.
REQ-026 The latency SHALL be 5 cycles from operator acceptance to the push edge, and 1 cycle for an operand push.
REQ-027 stk_push and stk_pop SHALL never be high in the same cycle.
REQ-028 The FSM SHALL issue no push or pop outside the cases above.
REQ-029 ERR SHALL hold tok_ready=0 and err=1, and keep err_code stable.
REQ-030 clr=1 in ERR SHALL return the FSM to IDLE on the next edge and zero err and err_code; the stack contents SHALL be left untouched; clr SHALL be ignored in other states.
REQ-031 After an underflow in GETB, the popped B SHALL be discarded.

Reset
REQ-032 When rst=0, the block SHALL asynchronously force state=IDLE, result=0, result_valid=0, err=0, err_code=00, and latched A, B and opcode to 0.
REQ-033 A reset asserted mid-operation SHALL abandon the operation with no further push or pop.
REQ-034 After rst deasserts, tok_ready SHALL be 1 in the first cycle.

Structure
REQ-035 The opcode constants, error-code constants and the FSM state encoding SHALL live in the shared package rpn_pkg.
REQ-036 The arithmetic SHALL be a combinational sub-module rpn_alu(a, b, op, y), instantiated once.
REQ-037 The sequencer SHALL contain no stack storage; it is the upstream driver of the stack block.

Verification
REQ-038 The bench SHALL push operand 5, push operand 3, then apply op 000: result=8 with result_valid 5 cycles after op acceptance, and the stack SHALL hold exactly one word, 8.
REQ-039 The bench SHALL push 2, push 7, then apply op 001 at DATA_WIDTH=8: result=0xFB (wrap).
REQ-040 The bench SHALL apply op 000 to an empty stack: no pop, err=1, err_code=10, tok_ready=0; then clr=1 SHALL give err=0 and tok_ready=1 on the next cycle.
REQ-041 The bench SHALL push an operand with stk_full=1: stk_push stays 0, err_code=01.
REQ-042 The bench SHALL apply opcode 111: err_code=11 with no stack traffic.
REQ-043 The bench SHALL assert rst=0 during GETB: outputs reach their reset values immediately, with no later push, and tok_ready=1 after release.
